axi_lite_master_arbiter: RTL and testbench
==========================================

AXI_LITE_MASTER_ARBITER -- requirements
Module: axi_lite_master_arbiter

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, 32, AXI4-Lite and requester address width.
REQ-002 SHALL have parameter C_DATA_WIDTH, 32, AXI4-Lite and requester data width; C_DATA_WIDTH/8 strobe bits.
REQ-003 SHALL have port M_AXI_LITE_ACLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port M_AXI_LITE_ARESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports REQn_VALID (n=0,1)  input  1  requester n has a transaction pending.
REQ-006 SHALL have ports REQn_READY  output  1  request accepted when VALID&READY at a clock edge.
REQ-007 SHALL have ports REQn_WE  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports REQn_ADDR  input  C_ADDR_WIDTH  byte address.
REQ-009 SHALL have ports REQn_WDATA  input  C_DATA_WIDTH  write data.
REQ-010 SHALL have ports REQn_WSTRB  input  C_DATA_WIDTH/8  write byte strobes.
REQ-011 SHALL have ports REQn_DONE  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports REQn_RDATA  output  C_DATA_WIDTH  last read data for requester n.
REQ-013 SHALL have ports REQn_RESP  output  2  last BRESP/RRESP for requester n.
REQ-014 SHALL have AW ports M_AXI_LITE_AWADDR/AWPROT/AWVALID outputs (C_ADDR_WIDTH/3/1), AWREADY input 1.
REQ-015 SHALL have W ports M_AXI_LITE_WDATA/WSTRB/WVALID outputs (C_DATA_WIDTH/C_DATA_WIDTH/8/1), WREADY input 1.
REQ-016 SHALL have B ports M_AXI_LITE_BRESP input 2, BVALID input 1, BREADY output 1.
REQ-017 SHALL have AR ports M_AXI_LITE_ARADDR/ARPROT/ARVALID outputs (C_ADDR_WIDTH/3/1), ARREADY input 1.
REQ-018 SHALL have R ports M_AXI_LITE_RDATA input C_DATA_WIDTH, RRESP input 2, RVALID input 1, RREADY output 1.
REQ-019 SHALL have ports BUSY output 1 (state != IDLE) and GRANT output 1 (index of current/last owner).

Function
REQ-020 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, CMPL; exactly one transaction outstanding.
REQ-021 IDLE: REQn_READY high combinationally only for the arbitration winner among VALID requesters; other READY low; all READY low outside IDLE.
REQ-022 On handshake: latch ADDR/WDATA/WSTRB/WE and owner into GRANT; next state WR_REQ if WE else RD_REQ.
REQ-023 Arbitration: single VALID wins; both VALID -> requester not granted last (round-robin pointer updated at each handshake).
REQ-024 WR_REQ: AWVALID and WVALID asserted from entry; each drops independently after its own handshake; both done -> WR_RESP.
REQ-025 WR_RESP: BREADY high; on BVALID capture BRESP into REQn_RESP of owner -> CMPL.
REQ-026 RD_REQ: ARVALID high until ARREADY -> RD_DATA; RD_DATA: RREADY high; on RVALID capture RDATA/RRESP for owner -> CMPL.
REQ-027 CMPL: REQn_DONE of owner high one cycle -> IDLE; RDATA/RESP held until owner's next completion; writes do not alter RDATA.
REQ-028 Latency with zero-wait slave: handshake at cycle N, AXI valid at N+1, DONE at N+3 for both reads and writes.
REQ-029 AXI address/data/strobe SHALL be driven from latched registers, stable while VALID and not accepted; AWPROT=ARPROT=3'b000.
REQ-030 VALID dropped before READY SHALL have no effect; requester inputs may change freely after handshake.
REQ-031 SLVERR/DECERR SHALL pass through unmodified; no retry.

Reset
REQ-032 While M_AXI_LITE_ARESET high, asynchronously: state IDLE, all VALID/READY/DONE/BUSY outputs 0, GRANT 0, RDATA/RESP 0, AXI addr/data/strobe 0.
REQ-033 Reset mid-transaction SHALL abandon it (slave reset together); round-robin pointer resets so requester 0 wins first tie.

Configuration
REQ-034 With AXI_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win when both VALID (no pointer).
REQ-035 Without AXI_ARB_FIXED_PRIO_EN, round-robin per REQ-023.

Verification
REQ-036 Req0 write 0x00000010/0xDEADBEEF/strb 0xF, always-ready slave, BRESP 00 -> AW/W one cycle, REQ0_DONE at N+3, REQ0_RESP 00.
REQ-037 Req1 read 0x00000020, ARREADY delayed 4 cycles, RDATA 0x12345678 -> ARADDR stable 5 cycles, REQ1_RDATA 0x12345678 at DONE.
REQ-038 Both VALID continuously, reads -> GRANT 0,1,0,1; with AXI_ARB_FIXED_PRIO_EN -> 0,0,0.
REQ-039 AWREADY 3 cycles before WREADY -> AWVALID drops after its handshake, WVALID held, BREADY not before WR_RESP.
REQ-040 Reset asserted in RD_DATA -> outputs zero without clock edge; after release simultaneous requests grant requester 0.
REQ-041 RRESP 10 on req0 read -> REQ0_RESP 10, REQ1_RESP unchanged.

Source files
------------

// File: rtl/axi_lite_master_arbiter.sv
// axi_lite_master_arbiter
// Shares one AXI4-Lite master port between two simple requesters. One
// transaction is outstanding at a time; results are kept per requester.
// Optional build macro: AXI_ARB_FIXED_PRIO_EN -- when defined, requester 0
// always wins a tie; when undefined, ties are resolved round-robin.
module axi_lite_master_arbiter #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      M_AXI_LITE_ACLK,
  input  logic                      M_AXI_LITE_ARESET,
  // requester 0
  input  logic                      REQ0_VALID,
  output logic                      REQ0_READY,
  input  logic                      REQ0_WE,
  input  logic [C_ADDR_WIDTH-1:0]   REQ0_ADDR,
  input  logic [C_DATA_WIDTH-1:0]   REQ0_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] REQ0_WSTRB,
  output logic                      REQ0_DONE,
  output logic [C_DATA_WIDTH-1:0]   REQ0_RDATA,
  output logic [1:0]                REQ0_RESP,
  // requester 1
  input  logic                      REQ1_VALID,
  output logic                      REQ1_READY,
  input  logic                      REQ1_WE,
  input  logic [C_ADDR_WIDTH-1:0]   REQ1_ADDR,
  input  logic [C_DATA_WIDTH-1:0]   REQ1_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] REQ1_WSTRB,
  output logic                      REQ1_DONE,
  output logic [C_DATA_WIDTH-1:0]   REQ1_RDATA,
  output logic [1:0]                REQ1_RESP,
  // AXI4-Lite write address channel
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_LITE_AWADDR,
  output logic [2:0]                M_AXI_LITE_AWPROT,
  output logic                      M_AXI_LITE_AWVALID,
  input  logic                      M_AXI_LITE_AWREADY,
  // AXI4-Lite write data channel
  output logic [C_DATA_WIDTH-1:0]   M_AXI_LITE_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_AXI_LITE_WSTRB,
  output logic                      M_AXI_LITE_WVALID,
  input  logic                      M_AXI_LITE_WREADY,
  // AXI4-Lite write response channel
  input  logic [1:0]                M_AXI_LITE_BRESP,
  input  logic                      M_AXI_LITE_BVALID,
  output logic                      M_AXI_LITE_BREADY,
  // AXI4-Lite read address channel
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_LITE_ARADDR,
  output logic [2:0]                M_AXI_LITE_ARPROT,
  output logic                      M_AXI_LITE_ARVALID,
  input  logic                      M_AXI_LITE_ARREADY,
  // AXI4-Lite read data channel
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_LITE_RDATA,
  input  logic [1:0]                M_AXI_LITE_RRESP,
  input  logic                      M_AXI_LITE_RVALID,
  output logic                      M_AXI_LITE_RREADY,
  // status
  output logic                      BUSY,
  output logic                      GRANT
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    CMPL    = 3'd5
  } state_t;

  state_t state, next_state;

  logic                      winner;
  logic                      accept;
  logic                      sel_we;
  logic [C_ADDR_WIDTH-1:0]   sel_addr;
  logic [C_DATA_WIDTH-1:0]   sel_wdata;
  logic [C_DATA_WIDTH/8-1:0] sel_wstrb;

  logic [C_ADDR_WIDTH-1:0]   addr_q;
  logic [C_DATA_WIDTH-1:0]   wdata_q;
  logic [C_DATA_WIDTH/8-1:0] wstrb_q;
  logic                      grant_q;
  logic                      aw_done_q;
  logic                      w_done_q;
  logic [C_DATA_WIDTH-1:0]   rdata0_q;
  logic [C_DATA_WIDTH-1:0]   rdata1_q;
  logic [1:0]                resp0_q;
  logic [1:0]                resp1_q;

  logic aw_hs;
  logic w_hs;

`ifndef AXI_ARB_FIXED_PRIO_EN
  logic rr_prio_q;
`endif

  // Arbitration: a lone requester wins; a tie goes to the priority holder.
  always_comb begin
    winner = 1'b0;
    if (REQ0_VALID && REQ1_VALID) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = rr_prio_q;
`endif
    end else if (REQ1_VALID) begin
      winner = 1'b1;
    end
  end

  assign accept    = (state == IDLE) && (REQ0_VALID || REQ1_VALID) && !M_AXI_LITE_ARESET;
  assign sel_we    = winner ? REQ1_WE    : REQ0_WE;
  assign sel_addr  = winner ? REQ1_ADDR  : REQ0_ADDR;
  assign sel_wdata = winner ? REQ1_WDATA : REQ0_WDATA;
  assign sel_wstrb = winner ? REQ1_WSTRB : REQ0_WSTRB;

  assign aw_hs = M_AXI_LITE_AWVALID && M_AXI_LITE_AWREADY;
  assign w_hs  = M_AXI_LITE_WVALID  && M_AXI_LITE_WREADY;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge M_AXI_LITE_ACLK or posedge M_AXI_LITE_ARESET) begin
    if (M_AXI_LITE_ARESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: walk the AXI channels for the accepted transaction.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = sel_we ? WR_REQ : RD_REQ;
      WR_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) next_state = WR_RESP;
      WR_RESP: if (M_AXI_LITE_BVALID) next_state = CMPL;
      RD_REQ:  if (M_AXI_LITE_ARREADY) next_state = RD_DATA;
      RD_DATA: if (M_AXI_LITE_RVALID) next_state = CMPL;
      CMPL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the current state and the per-channel completion flags.
  always_comb begin
    REQ0_READY         = accept && !winner;
    REQ1_READY         = accept && winner;
    REQ0_DONE          = (state == CMPL) && !grant_q;
    REQ1_DONE          = (state == CMPL) && grant_q;
    M_AXI_LITE_AWVALID = (state == WR_REQ) && !aw_done_q;
    M_AXI_LITE_WVALID  = (state == WR_REQ) && !w_done_q;
    M_AXI_LITE_BREADY  = (state == WR_RESP);
    M_AXI_LITE_ARVALID = (state == RD_REQ);
    M_AXI_LITE_RREADY  = (state == RD_DATA);
    BUSY               = (state != IDLE);
  end

  assign M_AXI_LITE_AWADDR = addr_q;
  assign M_AXI_LITE_ARADDR = addr_q;
  assign M_AXI_LITE_WDATA  = wdata_q;
  assign M_AXI_LITE_WSTRB  = wstrb_q;
  assign M_AXI_LITE_AWPROT = 3'b000;
  assign M_AXI_LITE_ARPROT = 3'b000;
  assign GRANT             = grant_q;
  assign REQ0_RDATA        = rdata0_q;
  assign REQ1_RDATA        = rdata1_q;
  assign REQ0_RESP         = resp0_q;
  assign REQ1_RESP         = resp1_q;

  // Latch the accepted request so the bus stays stable while the requester moves on.
  always_ff @(posedge M_AXI_LITE_ACLK or posedge M_AXI_LITE_ARESET) begin
    if (M_AXI_LITE_ARESET) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      grant_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= sel_addr;
        wdata_q   <= sel_wdata;
        wstrb_q   <= sel_wstrb;
        grant_q   <= winner;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
    end
  end

  // Capture slave responses into the owner's result registers; writes leave read data alone.
  always_ff @(posedge M_AXI_LITE_ACLK or posedge M_AXI_LITE_ARESET) begin
    if (M_AXI_LITE_ARESET) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
      resp0_q  <= 2'b00;
      resp1_q  <= 2'b00;
    end else if (state == WR_RESP && M_AXI_LITE_BVALID) begin
      if (grant_q) resp1_q <= M_AXI_LITE_BRESP;
      else         resp0_q <= M_AXI_LITE_BRESP;
    end else if (state == RD_DATA && M_AXI_LITE_RVALID) begin
      if (grant_q) begin
        rdata1_q <= M_AXI_LITE_RDATA;
        resp1_q  <= M_AXI_LITE_RRESP;
      end else begin
        rdata0_q <= M_AXI_LITE_RDATA;
        resp0_q  <= M_AXI_LITE_RRESP;
      end
    end
  end

`ifndef AXI_ARB_FIXED_PRIO_EN
  // Round-robin pointer: after every acceptance the other requester owns the next tie.
  always_ff @(posedge M_AXI_LITE_ACLK or posedge M_AXI_LITE_ARESET) begin
    if (M_AXI_LITE_ARESET) begin
      rr_prio_q <= 1'b0;
    end else if (accept) begin
      rr_prio_q <= !winner;
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb_axi_lite_master_arbiter
// Randomized bench for axi_lite_master_arbiter with a transaction-level
// reference model (arbitration order, latched bus fields, per-requester
// results). Honors AXI_ARB_FIXED_PRIO_EN when the design is built with it.
module tb_axi_lite_master_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic [1:0]  req_done;
  logic [31:0] req_rdata [2];
  logic [1:0]  req_resp  [2];

  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic        aw_valid, aw_ready, w_valid, w_ready;
  logic [1:0]  bresp, rresp;
  logic        b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready;
  logic        busy, grant;

  // slave configuration
  int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
  logic [1:0]  b_resp_next, r_resp_next;
  logic [31:0] r_data_next;
  bit          rand_resp;
  bit          zero_wait;

  // reference model state
  logic        last_grant;
  logic        cur_owner, cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;
  logic [31:0] exp_rdata [2];
  logic [1:0]  exp_resp  [2];
  bit          wr_active, aw_acc, w_acc;
  int          aw_cycles, w_cycles, ar_cycles, hs_cyc;
  logic        grant_log [$];

  int cyc;
  int checkCount;
  int errorCount;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_master_arbiter #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(32)) dut (
    .M_AXI_LITE_ACLK(clk),
    .M_AXI_LITE_ARESET(rst),
    .REQ0_VALID(req_valid[0]), .REQ0_READY(req_ready[0]), .REQ0_WE(req_we[0]),
    .REQ0_ADDR(req_addr[0]), .REQ0_WDATA(req_wdata[0]), .REQ0_WSTRB(req_wstrb[0]),
    .REQ0_DONE(req_done[0]), .REQ0_RDATA(req_rdata[0]), .REQ0_RESP(req_resp[0]),
    .REQ1_VALID(req_valid[1]), .REQ1_READY(req_ready[1]), .REQ1_WE(req_we[1]),
    .REQ1_ADDR(req_addr[1]), .REQ1_WDATA(req_wdata[1]), .REQ1_WSTRB(req_wstrb[1]),
    .REQ1_DONE(req_done[1]), .REQ1_RDATA(req_rdata[1]), .REQ1_RESP(req_resp[1]),
    .M_AXI_LITE_AWADDR(awaddr), .M_AXI_LITE_AWPROT(awprot),
    .M_AXI_LITE_AWVALID(aw_valid), .M_AXI_LITE_AWREADY(aw_ready),
    .M_AXI_LITE_WDATA(wdata), .M_AXI_LITE_WSTRB(wstrb),
    .M_AXI_LITE_WVALID(w_valid), .M_AXI_LITE_WREADY(w_ready),
    .M_AXI_LITE_BRESP(bresp), .M_AXI_LITE_BVALID(b_valid), .M_AXI_LITE_BREADY(b_ready),
    .M_AXI_LITE_ARADDR(araddr), .M_AXI_LITE_ARPROT(arprot),
    .M_AXI_LITE_ARVALID(ar_valid), .M_AXI_LITE_ARREADY(ar_ready),
    .M_AXI_LITE_RDATA(rdata), .M_AXI_LITE_RRESP(rresp),
    .M_AXI_LITE_RVALID(r_valid), .M_AXI_LITE_RREADY(r_ready),
    .BUSY(busy), .GRANT(grant)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave: each channel answers after its configured number of wait cycles.
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    aw_ready = 0; w_ready = 0; b_valid = 0; bresp = 0;
    ar_ready = 0; r_valid = 0; rdata = 0; rresp = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        aw_ready = 0; w_ready = 0; b_valid = 0; ar_ready = 0; r_valid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (aw_ready) begin aw_ready = 0; aw_cnt = 0; end
        else if (aw_valid) begin if (aw_cnt == aw_delay) aw_ready = 1; else aw_cnt++; end
        else aw_cnt = 0;

        if (w_ready) begin w_ready = 0; w_cnt = 0; end
        else if (w_valid) begin if (w_cnt == w_delay) w_ready = 1; else w_cnt++; end
        else w_cnt = 0;

        if (ar_ready) begin ar_ready = 0; ar_cnt = 0; end
        else if (ar_valid) begin if (ar_cnt == ar_delay) ar_ready = 1; else ar_cnt++; end
        else ar_cnt = 0;

        if (b_valid) begin b_valid = 0; b_cnt = 0; end
        else if (b_ready) begin
          if (b_cnt == b_delay) begin
            b_valid = 1;
            bresp = rand_resp ? 2'($urandom_range(0, 3)) : b_resp_next;
          end else b_cnt++;
        end else b_cnt = 0;

        if (r_valid) begin r_valid = 0; r_cnt = 0; end
        else if (r_ready) begin
          if (r_cnt == r_delay) begin
            r_valid = 1;
            rdata = rand_resp ? $urandom : r_data_next;
            rresp = rand_resp ? 2'($urandom_range(0, 3)) : r_resp_next;
          end else r_cnt++;
        end else r_cnt = 0;
      end
    end
  end

  // Reference model and protocol monitor, sampled on the falling edge.
  initial begin
    logic exp_win;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_grant = 1'b1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        exp_resp[0] = '0;  exp_resp[1] = '0;
        wr_active = 0; aw_acc = 0; w_acc = 0;
      end else begin
        if (b_ready) checkOutput("bready_early", {63'd0, aw_valid | w_valid}, 64'd0);
        if (wr_active && aw_acc) checkOutput("awvalid_after_hs", {63'd0, aw_valid}, 64'd0);
        if (wr_active && aw_acc && !w_acc) checkOutput("wvalid_held", {63'd0, w_valid}, 64'd1);
        if (aw_valid) begin
          checkOutput("awaddr", {32'd0, awaddr}, {32'd0, cur_addr});
          checkOutput("awprot", {61'd0, awprot}, 64'd0);
          aw_cycles++;
          if (aw_ready) aw_acc = 1;
        end
        if (w_valid) begin
          checkOutput("wdata", {28'd0, wstrb, wdata}, {28'd0, cur_wstrb, cur_wdata});
          w_cycles++;
          if (w_ready) w_acc = 1;
        end
        if (ar_valid) begin
          checkOutput("araddr", {29'd0, arprot, araddr}, {32'd0, cur_addr});
          ar_cycles++;
        end
        if (b_valid && b_ready) begin
          exp_resp[cur_owner] = bresp;
          wr_active = 0;
        end
        if (r_valid && r_ready) begin
          exp_rdata[cur_owner] = rdata;
          exp_resp[cur_owner]  = rresp;
        end
        if (req_done != 2'b00) begin
          checkOutput("done_owner", {62'd0, req_done}, cur_owner ? 64'd2 : 64'd1);
          checkOutput("grant", {63'd0, grant}, {63'd0, cur_owner});
          checkOutput("rdata0", {32'd0, req_rdata[0]}, {32'd0, exp_rdata[0]});
          checkOutput("rdata1", {32'd0, req_rdata[1]}, {32'd0, exp_rdata[1]});
          checkOutput("resp", {60'd0, req_resp[1], req_resp[0]}, {60'd0, exp_resp[1], exp_resp[0]});
          if (cur_we) begin
            checkOutput("aw_cycles", 64'(aw_cycles), 64'(aw_delay + 1));
            checkOutput("w_cycles", 64'(w_cycles), 64'(w_delay + 1));
          end else begin
            checkOutput("ar_cycles", 64'(ar_cycles), 64'(ar_delay + 1));
          end
          if (zero_wait) checkOutput("latency", 64'(cyc - hs_cyc), 64'd3);
          grant_log.push_back(grant);
        end
        if (req_ready != 2'b00) begin
          if (req_valid == 2'b11) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
            exp_win = 1'b0;
`else
            exp_win = ~last_grant;
`endif
          end else begin
            exp_win = req_valid[1];
          end
          checkOutput("ready_winner", {62'd0, req_ready}, exp_win ? 64'd2 : 64'd1);
          last_grant = exp_win;
          cur_owner  = exp_win;
          cur_we     = req_we[exp_win];
          cur_addr   = req_addr[exp_win];
          cur_wdata  = req_wdata[exp_win];
          cur_wstrb  = req_wstrb[exp_win];
          wr_active  = cur_we;
          aw_acc = 0; w_acc = 0;
          aw_cycles = 0; w_cycles = 0; ar_cycles = 0;
          hs_cyc = cyc;
        end
      end
    end
  end

  // One requester-side transaction: raise VALID, wait for acceptance, optionally wait for DONE.
  task automatic driveRequest(input int r, input logic we, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb, input bit wait_done);
    int n;
    @(posedge clk);
    #1;
    req_we[r] = we; req_addr[r] = addr; req_wdata[r] = data; req_wstrb[r] = strb;
    req_valid[r] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[r] && n < 200);
    if (!req_ready[r]) checkOutput("handshake_timeout", {63'd0, req_ready[r]}, 64'd1);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    req_we[r] = 1'($urandom); req_addr[r] = $urandom;
    req_wdata[r] = $urandom; req_wstrb[r] = 4'($urandom);
    if (wait_done) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!req_done[r] && n < 200);
      if (!req_done[r]) checkOutput("done_timeout", {63'd0, req_done[r]}, 64'd1);
    end
  endtask

  // Launch random transactions on the requesters selected by pattern bits, concurrently.
  task automatic applyStimulus(input int pattern);
    logic [1:0]  we;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  s0, s1;
    we = 2'($urandom);
    a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
    s0 = 4'($urandom); s1 = 4'($urandom);
    fork
      begin if (pattern[0]) driveRequest(0, we[0], a0, d0, s0, 1); end
      begin if (pattern[1]) driveRequest(1, we[1], a1, d1, s1, 1); end
    join
  endtask

  task automatic setDelays(input int aw, input int w, input int b, input int ar, input int r);
    aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
    zero_wait = (aw == 0) && (w == 0) && (b == 0) && (ar == 0) && (r == 0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ctrl"},
                {53'd0, req_ready, req_done, aw_valid, w_valid, b_ready, ar_valid, r_ready, busy, grant},
                64'd0);
    checkOutput({tag, "_rdata0"}, {32'd0, req_rdata[0]}, 64'd0);
    checkOutput({tag, "_rdata1"}, {32'd0, req_rdata[1]}, 64'd0);
    checkOutput({tag, "_resp"}, {60'd0, req_resp[1], req_resp[0]}, 64'd0);
    checkOutput({tag, "_addr"}, {awaddr, araddr}, 64'd0);
    checkOutput({tag, "_wdata"}, {28'd0, wstrb, wdata}, 64'd0);
  endtask

  initial begin
    int exp_log [6];
    int n;
    checkCount = 0; errorCount = 0; cyc = 0;
    req_valid = 2'b00; req_we = 2'b00;
    req_addr[0] = '0; req_addr[1] = '0; req_wdata[0] = '0; req_wdata[1] = '0;
    req_wstrb[0] = '0; req_wstrb[1] = '0;
    rand_resp = 0; b_resp_next = 0; r_resp_next = 0; r_data_next = 0;
    setDelays(0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    checkReset("por");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] zero-wait write from requester 0");
    b_resp_next = 2'b00;
    driveRequest(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1);
    checkOutput("req0_wr_resp", {62'd0, req_resp[0]}, 64'd0);

    $display("[TB] requester 1 read with delayed ARREADY");
    setDelays(0, 0, 0, 4, 0);
    r_data_next = 32'h1234_5678; r_resp_next = 2'b00;
    driveRequest(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1);
    checkOutput("req1_rdata", {32'd0, req_rdata[1]}, 64'h1234_5678);

    $display("[TB] AWREADY well ahead of WREADY");
    setDelays(0, 3, 0, 0, 0);
    b_resp_next = 2'b01;
    driveRequest(0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'h5, 1);
    checkOutput("req1_rdata_after_write", {32'd0, req_rdata[1]}, 64'h1234_5678);

    $display("[TB] SLVERR read on requester 0");
    setDelays(0, 0, 0, 0, 0);
    r_resp_next = 2'b10; r_data_next = 32'hA5A5_0001;
    driveRequest(0, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 1);
    checkOutput("req0_slverr", {62'd0, req_resp[0]}, 64'd2);
    checkOutput("req1_resp_kept", {62'd0, req_resp[1]}, 64'd0);

    $display("[TB] randomized traffic");
    rand_resp = 1;
    for (int i = 0; i < 40; i++) begin
      setDelays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      applyStimulus($urandom_range(1, 3));
    end

    $display("[TB] reset during read data phase");
    setDelays(0, 0, 0, 0, 50);
    driveRequest(1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!r_ready && n < 50);
    checkOutput("reached_rd_data", {63'd0, r_ready}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkReset("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    setDelays(0, 0, 0, 0, 0);

    $display("[TB] both requesters continuously valid");
    grant_log.delete();
    fork
      begin
        for (int k = 0; k < 3; k++) driveRequest(0, 1'b0, $urandom, 32'h0, 4'h0, 1);
      end
      begin
        for (int k = 0; k < 3; k++) driveRequest(1, 1'b0, $urandom, 32'h0, 4'h0, 1);
      end
    join
`ifdef AXI_ARB_FIXED_PRIO_EN
    exp_log = '{0, 0, 0, 1, 1, 1};
`else
    exp_log = '{0, 1, 0, 1, 0, 1};
`endif
    checkOutput("grant_seq_len", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size())
        checkOutput($sformatf("grant_seq%0d", i), {63'd0, grant_log[i]}, 64'(exp_log[i]));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
